// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmit feeder and its neighbouring
// transmitter/receiver benches.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_FRAME_CYCLES = 94;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port plus transmitter drive signals of the UART transmit feeder.
interface uart_tx_feeder_if #(
  parameter int DEPTH = 4
);

  logic                              wr_en;
  logic [uart_pkg::UART_DATA_W-1:0]  wr_data;
  logic                              full;
  logic [$clog2(DEPTH):0]            count;
  logic                              overflow;
  logic                              TXStart;
  logic [uart_pkg::UART_DATA_W-1:0]  datain;
  logic                              busy;

  modport master (
    output wr_en, wr_data,
    input  full, count, overflow, TXStart, datain, busy
  );

  modport slave (
    input  wr_en, wr_data,
    output full, count, overflow, TXStart, datain, busy
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with registered occupancy and full flag.
// Writes while full are dropped; the caller only pops when count is non-zero.
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             push;

  assign push = wr && !full;
  assign head = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and paces them onto the UART transmitter, one byte per
// FRAME_CYCLES, back-to-back with no idle gap while bytes are waiting.
//
// state | meaning
// IDLE  | nothing being sent; TXStart low, datain keeps the last byte
// HOLD  | byte on datain for FRAME_CYCLES cycles; TXStart high
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FRAME_CYCLES = UART_FRAME_CYCLES
) (
  input  logic              clk2,
  input  logic              reset,
  uart_tx_feeder_if.slave   bus
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CYCLES - 1);

  feeder_state_t          state, state_nxt;
  logic [CW-1:0]          frame_cnt, frame_cnt_nxt;
  logic                   txstart_q, txstart_nxt;
  logic [UART_DATA_W-1:0] datain_q, datain_nxt;
  logic                   overflow_q;
  logic                   pop;
  logic                   have_byte;
  logic [UART_DATA_W-1:0] head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk2),
    .rst     (reset),
    .wr      (bus.wr_en),
    .wr_data (bus.wr_data),
    .pop     (pop),
    .head    (head),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  assign have_byte = (fifo_count != '0);

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    txstart_nxt   = txstart_q;
    datain_nxt    = datain_q;
    pop           = 1'b0;
    unique case (state)
      IDLE: begin
        txstart_nxt = 1'b0;
        if (have_byte) begin
          pop           = 1'b1;
          datain_nxt    = head;
          txstart_nxt   = 1'b1;
          frame_cnt_nxt = FRAME_LOAD;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (frame_cnt != '0) begin
          frame_cnt_nxt = frame_cnt - 1'b1;
        end else if (have_byte) begin
          // Frame boundary with more data: chain the next byte without a gap.
          pop           = 1'b1;
          datain_nxt    = head;
          frame_cnt_nxt = FRAME_LOAD;
        end else begin
          txstart_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      txstart_q  <= 1'b0;
      datain_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= frame_cnt_nxt;
      txstart_q  <= txstart_nxt;
      datain_q   <= datain_nxt;
      overflow_q <= bus.wr_en && fifo_full;
    end
  end

  assign bus.TXStart  = txstart_q;
  assign bus.datain   = datain_q;
  assign bus.busy     = (state == HOLD);
  assign bus.full     = fifo_full;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and pacing stage sitting directly upstream of the UART `transmitter`. It accepts bytes from a host-side write port into a small FIFO. It drives the transmitter's `TXStart`/`datain` inputs, holding each byte stable for exactly one frame period. Back-to-back bytes go out with `TXStart` held high, with no idle gap. The transmitter has no done/ready output, so frame pacing is owned entirely by this block's frame counter.

## Interface
- `DEPTH`, 4: FIFO depth in bytes; power of two, ≥2.
- `FRAME_CYCLES`, 94: `clk2` cycles each byte is held on `datain`; must match the transmitter's frame length; ≥2.
- `clk2`  input  1  system/sampling clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `wr_en`  input  1  host write strobe; one byte per cycle.
- `wr_data`  input  8  host byte.
- `full`  output  1  FIFO holds DEPTH bytes; writes ignored.
- `count`  output  $clog2(DEPTH)+1  bytes waiting in FIFO (excludes byte on `datain`).
- `overflow`  output  1  one-cycle pulse: write attempted while `full`.
- `TXStart`  output  1  to transmitter; high while a frame is being sent.
- `datain`  output  8  to transmitter; byte currently being sent.
- `busy`  output  1  high in HOLD state.

## Operation
- States: IDLE, HOLD.
- IDLE:
  - `TXStart`=0.
  - `datain` retains the last sent byte.
  - On an edge with `count`≠0: pop the head byte into `datain`, set `TXStart`=1, load `frame_cnt`=FRAME_CYCLES-1, and go to HOLD.
- HOLD:
  - `frame_cnt` decrements once per cycle.
  - On the edge where `frame_cnt`==0 and `count`≠0: pop the next byte into `datain`, reload the counter, stay in HOLD. `TXStart` stays 1 with no gap.
  - On the edge where `frame_cnt`==0 and `count`==0: `TXStart`←0, go to IDLE.
- Write: accepted iff `wr_en` && !`full`, where `full` is the registered value at that edge.
  - Write while full: byte dropped, `overflow`=1 for the next cycle, FIFO unchanged.
- Simultaneous write and pop on the same edge:
  - Both occur; `count` is unchanged.
  - If `full` was set, the write is rejected even though a pop occurs (overflow pulses).
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` tracks occupancy 0..DEPTH.
- `full` = (`count`==DEPTH), registered alongside `count`.
- Reset, asynchronous, at any time including mid-frame:
  - State←IDLE, `TXStart`=0, `datain`=8'h00.
  - `count`=0, pointers=0, `full`=0, `overflow`=0, `busy`=0, `frame_cnt`=0.
  - FIFO contents are discarded; the frame in progress is abandoned.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Write at edge N into an empty, idle block:
  - `count`=1 after N.
  - Pop at N+1: `TXStart`=1 and `datain` valid after N+1, i.e. 2-cycle latency.
  - `count` returns to 0 after N+1.
- Each byte stays on `datain` for exactly FRAME_CYCLES cycles.
- With DEPTH+1 bytes queued (DEPTH in FIFO plus one on `datain`), `TXStart` stays high for (DEPTH+1)·FRAME_CYCLES cycles continuously.
- After the last frame expires, `TXStart` falls on the same edge that `busy` falls.
- `overflow` asserts the cycle after the rejected write and lasts one cycle.

## Structure
- Shared `uart_pkg`: `UART_DATA_W`=8, the `feeder_state_t` enum (IDLE, HOLD), and the default frame length constant shared with the transmitter/receiver benches.
- One sub-module, `uart_sync_fifo` (parameters DEPTH, WIDTH):
  - ports: write, pop, head data, count, full.
- The top holds the FSM, frame counter and output registers.

## Test plan
- Reset then write 8'h95 at cycle 10 → `TXStart`=1 and `datain`=8'h95 from cycle 12 through cycle 105; `TXStart`=0 at cycle 106.
- Write 8'h95, 8'hB9, 8'hC3, 8'hCC on consecutive cycles → `datain` steps 95→B9→C3→CC every 94 cycles; `TXStart` is high continuously for 376 cycles.
- DEPTH=4: write 6 bytes back-to-back from idle:
  - byte 0 popped after 1 cycle; bytes 1–4 fill the FIFO, `full`=1.
  - 6th write dropped, `overflow` pulses once.
  - exactly 5 bytes are transmitted.
- Write while full on the same edge as a HOLD pop → write rejected, `overflow` pulses, `count` drops DEPTH→DEPTH-1.
- Assert `reset` at cycle 50 of a frame with 2 bytes queued → immediately `TXStart`=0, `datain`=8'h00, `count`=0. A new write after release transmits normally with 2-cycle latency.
